// File: rtl/jam_pkg.sv
// Shared constants and types for the job-assignment cost feeder.
package jam_pkg;

  localparam int unsigned COST_W = 7;
  localparam int unsigned N      = 8;
  localparam int unsigned MC_W   = 10;
  localparam int unsigned CNT_W  = 4;

  typedef logic [COST_W-1:0] cost_t;
  typedef logic [5:0]        addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } run_state_e;

endpackage

// File: rtl/jam_cost_feeder_if.sv
// Load stream, solver port and result port of the cost feeder.
interface jam_cost_feeder_if;
  import jam_pkg::*;

  logic              in_valid;
  logic              in_ready;
  cost_t             in_data;
  logic              sol_rst;
  logic [2:0]        sol_W;
  logic [2:0]        sol_J;
  cost_t             sol_Cost;
  logic              sol_Valid;
  logic [MC_W-1:0]   sol_MinCost;
  logic [CNT_W-1:0]  sol_MatchCount;
  logic              res_valid;
  logic              res_ready;
  logic [MC_W-1:0]   res_min_cost;
  logic [CNT_W-1:0]  res_match_count;

  // master: environment (source, solver, consumer); slave: the feeder itself
  modport master (
    output in_valid, in_data, sol_W, sol_J, sol_Valid, sol_MinCost, sol_MatchCount, res_ready,
    input  in_ready, sol_rst, sol_Cost, res_valid, res_min_cost, res_match_count
  );

  modport slave (
    input  in_valid, in_data, sol_W, sol_J, sol_Valid, sol_MinCost, sol_MatchCount, res_ready,
    output in_ready, sol_rst, sol_Cost, res_valid, res_min_cost, res_match_count
  );

endinterface

// File: rtl/jam_cost_bank.sv
// Two 64-entry cost banks: one write port, one registered read port.
module jam_cost_bank
  import jam_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_we,
  input  logic  i_wr_bank,
  input  addr_t i_wr_addr,
  input  cost_t i_wr_data,
  input  logic  i_rd_bank,
  input  addr_t i_rd_addr,
  output cost_t o_rd_data
);

  cost_t r_mem [2][64];
  cost_t r_rd_data;

  // Storage is deliberately not reset; stale contents are never read as valid data.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/jam_cost_feeder.sv
// Double-buffered 8x8 cost loader that sequences solver runs and holds each result.
module jam_cost_feeder
  import jam_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  jam_cost_feeder_if.slave bus
);

  logic [1:0]       r_full;
  logic [1:0]       w_full_d;
  logic             r_ld;
  logic             r_act;
  addr_t            r_cnt;
  run_state_e       r_state;
  logic             r_res_valid;
  logic [MC_W-1:0]  r_min_cost;
  logic [CNT_W-1:0] r_match_cnt;

  logic w_in_ready;
  logic w_wr;
  logic w_ld_done;
  logic w_accept;

  assign w_in_ready = !r_full[r_ld];
  assign w_wr       = bus.in_valid && w_in_ready;
  assign w_ld_done  = w_wr && (r_cnt == 6'd63);
  assign w_accept   = (r_state == REPORT) && r_res_valid && bus.res_ready;

  // Load completion and result accept always target different banks here.
  always_comb begin
    w_full_d = r_full;
    if (w_ld_done) w_full_d[r_ld]  = 1'b1;
    if (w_accept)  w_full_d[r_act] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full      <= 2'b00;
      r_ld        <= 1'b0;
      r_act       <= 1'b0;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_res_valid <= 1'b0;
      r_min_cost  <= '0;
      r_match_cnt <= '0;
    end else begin
      r_full <= w_full_d;
      if (w_wr) begin
        r_cnt <= r_cnt + 6'd1;
        if (w_ld_done) r_ld <= ~r_ld;
      end
      unique case (r_state)
        IDLE: begin
          if (r_full[r_act]) r_state <= RUN;
        end
        RUN: begin
          if (bus.sol_Valid) begin
            r_min_cost  <= bus.sol_MinCost;
            r_match_cnt <= bus.sol_MatchCount;
            r_res_valid <= 1'b1;
            r_state     <= REPORT;
          end
        end
        REPORT: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            r_act       <= ~r_act;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  jam_cost_bank u_bank (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_we      (w_wr),
    .i_wr_bank (r_ld),
    .i_wr_addr (r_cnt),
    .i_wr_data (bus.in_data),
    .i_rd_bank (r_act),
    .i_rd_addr ({bus.sol_W, bus.sol_J}),
    .o_rd_data (bus.sol_Cost)
  );

  assign bus.in_ready        = w_in_ready;
  assign bus.sol_rst         = (r_state != RUN);
  assign bus.res_valid       = r_res_valid;
  assign bus.res_min_cost    = r_min_cost;
  assign bus.res_match_count = r_match_cnt;

endmodule

// File: doc/jam_cost_feeder.md
Name: jam_cost_feeder

Overview:
- Upstream stage of the job-assignment solver.
- Accepts a row-major stream of 8x8 worker/job cost words over a valid/ready handshake and double-buffers whole matrices.
- Serves the solver's (W,J) read port with one-cycle registered latency, and sequences solver runs by driving its reset.
- Captures MinCost/MatchCount when the solver raises Valid and presents them on a valid/ready result port, so the next matrix loads while the current one is solved.

Parameters:
COST_W, 7, width of one cost word
N, 8, matrix dimension (workers = jobs); fixed at 8, index width 3
MC_W, 10, width of MinCost
CNT_W, 4, width of MatchCount

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
in_valid  in  1  cost word present
in_ready  out  1  feeder can accept a cost word
in_data  in  COST_W  cost word; stream order index k=0..63 maps to W=k[5:3], J=k[2:0]
sol_rst  out  1  reset to solver; high holds solver idle
sol_W  in  3  solver worker address
sol_J  in  3  solver job address
sol_Cost  out  COST_W  cost[sol_W][sol_J] of previous cycle
sol_Valid  in  1  solver done
sol_MinCost  in  MC_W  solver result
sol_MatchCount  in  CNT_W  solver result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_min_cost  out  MC_W  latched MinCost
res_match_count  out  CNT_W  latched MatchCount

Behaviour:
- Reset is synchronous on CLK, active-high.
- Reset values: in_ready=1, sol_rst=1, sol_Cost=0, res_valid=0, res_min_cost=0, res_match_count=0.
- Reset also clears bank-full flags full[1:0]=0, load bank ld=0, active bank act=0, word counter cnt=0 and FSM state to IDLE.
- Reset mid-load or mid-solve discards all buffered data; storage contents need not be cleared.
- Storage: two banks of 64 x COST_W.
- Load side:
  - in_ready = !full[ld], combinational from registers.
  - On in_valid && in_ready: bank[ld][cnt] <= in_data; cnt++.
  - When cnt==63 is written: full[ld]<=1, ld<=~ld, cnt<=0.
  - in_valid without in_ready: no effect, and the word must be held by the source.
- Read side:
  - sol_Cost <= bank[act][{sol_W,sol_J}] every cycle, giving 1-cycle latency.
  - The solver samples Cost for the address it drove one cycle earlier.
- Run FSM:
  - IDLE: sol_rst=1. If full[act], go to RUN next cycle. IDLE lasts at least 1 cycle per problem, so sol_rst is high for at least 1 cycle between runs.
  - RUN: sol_rst=0. On sol_Valid: res_min_cost<=sol_MinCost, res_match_count<=sol_MatchCount, res_valid<=1, go to REPORT.
  - REPORT: sol_rst=1 (solver frozen), res_valid held with stable data until res_ready. On the res_valid && res_ready cycle: res_valid<=0, full[act]<=0, act<=~act, go to IDLE.
- Bank conflict rule: ld==act only while full[act]==0 and the FSM is in IDLE. The loader therefore never writes the bank being solved.
- Simultaneous events:
  - A load completion setting full[ld] and a REPORT accept clearing full[act] in the same cycle touch different flags; both take effect.
  - If the other bank is already full at the accept, IDLE lasts exactly 1 cycle, then RUN.
- sol_Valid outside RUN is ignored.
- sol_W/sol_J values are used unchecked (3-bit, always in range).

Decomposition:
- Shared package jam_pkg holds: COST_W, N, MC_W, CNT_W constants; typedef cost_t (logic [COST_W-1:0]); typedef addr_t (logic [5:0]); enum run_state_e {IDLE, RUN, REPORT}.
- One natural sub-module: jam_cost_bank, a 2-bank 64-entry register file with one write port and one registered read port (bank-select plus 6-bit address each).
- Top holds the load counter, flags and FSM.

Test Plan:
- Load 64 words with value k at index k, no gaps → in_ready stays 1. In the cycle after full, sol_rst falls. Drive sol_W=2, sol_J=5 → sol_Cost=21 on the following cycle.
- Load matrix A (all 3), then B (all 5) back-to-back while the solver is in RUN → B accepted. A third stream sees in_ready=0 after B completes and stays 0 until the A result is accepted.
- In RUN pulse sol_Valid with sol_MinCost=123, sol_MatchCount=2, and hold res_ready=0 for 5 cycles → res_valid=1, outputs stable at 123/2, sol_rst=1. Raise res_ready → res_valid=0 next cycle; act switches to B, and sol_rst stays high for exactly 1 cycle before RUN.
- Drop in_valid randomly (50%) during a load, then probe address (7,7) → sol_Cost equals the 64th word and no words are lost or duplicated.
- Assert RST after 30 words loaded → in_ready=1, sol_rst=1, res_valid=0. A fresh 64-word stream is then required before sol_rst falls.
- sol_Valid pulsed while in IDLE (no full bank) → no res_valid and no state change.
